// File: rtl/part_tester_pkg.sv
// Shared op codes, defaults and FSM state encoding for the part-tester pin sequencer.
package part_tester_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [2:0] OP_RESET     = 3'd0;
   localparam logic [2:0] OP_SHIFT_IN  = 3'd1;
   localparam logic [2:0] OP_SHIFT_OUT = 3'd2;
   localparam logic [2:0] OP_EXECUTE   = 3'd3;
   localparam logic [2:0] OP_FREE_RUN  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRST,
      ST_WAIT_IN,
      ST_LOW,
      ST_HIGH,
      ST_WAIT_OUT,
      ST_FREE,
      ST_FIN
   } state_t;

   // Ops whose length comes from cmd_count_i.
   function automatic logic op_is_counted(input logic [2:0] op);
      return (op == OP_SHIFT_IN) || (op == OP_SHIFT_OUT) || (op == OP_EXECUTE);
   endfunction

endpackage

// File: rtl/part_clk_gen.sv
// Part-clock phase timer: each start runs one CLK_DIV-cycle phase at the requested level.
module part_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic start_i,
   input  logic phase_i,
   input  logic stop_i,
   output logic phase_done_o,
   output logic part_clk_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             pclk_q, pclk_d;

   assign phase_done_o = busy_q && (cnt_q == '0);
   assign part_clk_o   = pclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      pclk_d = pclk_q;
      if (busy_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - DIV_W'(1);
      end
      if (phase_done_o) begin
         busy_d = 1'b0;
      end
      // Stop wins so the clock always parks low when the sequencer leaves a phase.
      if (stop_i) begin
         busy_d = 1'b0;
         pclk_d = 1'b0;
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = DIV_W'(CLK_DIV - 1);
         pclk_d = phase_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         pclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         pclk_q <= pclk_d;
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Part-under-test pin sequencer: reset, scan in/out with handshakes, counted and free-run clocking.
module scan_sequencer
   import part_tester_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int RST_CYCLES = 8,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_op_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   input  logic             pause_i,
   input  logic             bit_in_valid_i,
   input  logic             bit_in_i,
   output logic             bit_in_ready_o,
   output logic             bit_out_valid_o,
   output logic             bit_out_o,
   input  logic             bit_out_ready_i,
   output logic             done_o,
   output logic [CNT_W-1:0] cycles_o,
   output logic             part_clk_o,
   output logic             part_rstn_o,
   output logic             test_se_o,
   output logic             test_tm_o,
   output logic             scan_in_o,
   input  logic             scan_out_i
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [RW-1:0]    prst_q, prst_d;
   logic             part_rstn_q, part_rstn_d;
   logic             se_q, se_d;
   logic             tm_q, tm_d;
   logic             scan_in_q, scan_in_d;
   logic             bit_in_ready_q, bit_in_ready_d;
   logic             bit_out_valid_q, bit_out_valid_d;
   logic             bit_out_q, bit_out_d;
   logic             done_q, done_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             pause_seen_q, pause_seen_d;

   logic gen_start, gen_phase, gen_stop, gen_done, gen_clk;
   logic fin_now;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   part_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (gen_start),
      .phase_i      (gen_phase),
      .stop_i       (gen_stop),
      .phase_done_o (gen_done),
      .part_clk_o   (gen_clk)
   );

   always_comb begin
      state_d         = state_q;
      op_d            = op_q;
      remaining_d     = remaining_q;
      cycles_d        = cycles_q;
      prst_d          = prst_q;
      part_rstn_d     = part_rstn_q;
      se_d            = se_q;
      tm_d            = tm_q;
      scan_in_d       = scan_in_q;
      bit_in_ready_d  = 1'b0;
      bit_out_valid_d = bit_out_valid_q;
      bit_out_d       = bit_out_q;
      done_d          = 1'b0;
      pause_seen_d    = pause_seen_q;
      gen_start       = 1'b0;
      gen_phase       = 1'b0;
      gen_stop        = 1'b0;
      fin_now         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               op_d         = cmd_op_i;
               remaining_d  = cmd_count_i;
               cycles_d     = '0;
               pause_seen_d = pause_i;
               scan_in_d    = 1'b0;
               if (cmd_op_i == OP_RESET) begin
                  state_d     = ST_PRST;
                  part_rstn_d = 1'b0;
                  prst_d      = RW'(RST_CYCLES - 1);
               end else if (op_is_counted(cmd_op_i)) begin
                  if (cmd_count_i == '0) begin
                     fin_now = 1'b1;
                  end else begin
                     se_d = (cmd_op_i != OP_EXECUTE);
                     tm_d = (cmd_op_i != OP_EXECUTE);
                     if (cmd_op_i == OP_SHIFT_IN) begin
                        state_d = ST_WAIT_IN;
                     end else begin
                        gen_start = 1'b1;
                        state_d   = ST_LOW;
                     end
                  end
               end else if (cmd_op_i == OP_FREE_RUN) begin
                  se_d      = 1'b0;
                  tm_d      = 1'b0;
                  gen_start = 1'b1;
                  state_d   = ST_FREE;
               end else begin
                  fin_now = 1'b1;
               end
            end
         end
         ST_PRST: begin
            if (prst_q == '0) begin
               part_rstn_d = 1'b1;
               fin_now     = 1'b1;
            end else begin
               prst_d = prst_q - RW'(1);
            end
         end
         ST_WAIT_IN: begin
            if (bit_in_valid_i) begin
               bit_in_ready_d = 1'b1;
               scan_in_d      = bit_in_i;
               gen_start      = 1'b1;
               state_d        = ST_LOW;
            end
         end
         ST_LOW: begin
            if (gen_done) begin
               // Shift-out samples the part just before the rising edge, then waits for the consumer.
               if (op_q == OP_SHIFT_OUT) begin
                  bit_out_d       = scan_out_i;
                  bit_out_valid_d = 1'b1;
                  state_d         = ST_WAIT_OUT;
               end else begin
                  gen_start = 1'b1;
                  gen_phase = 1'b1;
                  cycles_d  = sat_inc(cycles_q);
                  state_d   = ST_HIGH;
               end
            end
         end
         ST_WAIT_OUT: begin
            if (bit_out_ready_i) begin
               bit_out_valid_d = 1'b0;
               gen_start       = 1'b1;
               gen_phase       = 1'b1;
               cycles_d        = sat_inc(cycles_q);
               state_d         = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (gen_done) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) begin
                  fin_now = 1'b1;
               end else if (op_q == OP_SHIFT_IN) begin
                  gen_stop = 1'b1;
                  state_d  = ST_WAIT_IN;
               end else begin
                  gen_start = 1'b1;
                  state_d   = ST_LOW;
               end
            end
         end
         ST_FREE: begin
            if (pause_i) begin
               pause_seen_d = 1'b1;
            end
            if (gen_done) begin
               if (!gen_clk) begin
                  gen_start = 1'b1;
                  gen_phase = 1'b1;
                  cycles_d  = sat_inc(cycles_q);
               end else if (pause_seen_q || pause_i) begin
                  fin_now = 1'b1;
               end else begin
                  gen_start = 1'b1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (fin_now) begin
         state_d   = ST_FIN;
         done_d    = 1'b1;
         se_d      = 1'b0;
         tm_d      = 1'b0;
         scan_in_d = 1'b0;
         gen_stop  = 1'b1;
      end

      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         op_q            <= OP_RESET;
         remaining_q     <= '0;
         cycles_q        <= '0;
         prst_q          <= '0;
         part_rstn_q     <= 1'b1;
         se_q            <= 1'b0;
         tm_q            <= 1'b0;
         scan_in_q       <= 1'b0;
         bit_in_ready_q  <= 1'b0;
         bit_out_valid_q <= 1'b0;
         bit_out_q       <= 1'b0;
         done_q          <= 1'b0;
         cmd_ready_q     <= 1'b1;
         pause_seen_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         op_q            <= op_d;
         remaining_q     <= remaining_d;
         cycles_q        <= cycles_d;
         prst_q          <= prst_d;
         part_rstn_q     <= part_rstn_d;
         se_q            <= se_d;
         tm_q            <= tm_d;
         scan_in_q       <= scan_in_d;
         bit_in_ready_q  <= bit_in_ready_d;
         bit_out_valid_q <= bit_out_valid_d;
         bit_out_q       <= bit_out_d;
         done_q          <= done_d;
         cmd_ready_q     <= cmd_ready_d;
         pause_seen_q    <= pause_seen_d;
      end
   end

   assign cmd_ready_o     = cmd_ready_q;
   assign bit_in_ready_o  = bit_in_ready_q;
   assign bit_out_valid_o = bit_out_valid_q;
   assign bit_out_o       = bit_out_q;
   assign done_o          = done_q;
   assign cycles_o        = cycles_q;
   assign part_clk_o      = gen_clk;
   assign part_rstn_o     = part_rstn_q;
   assign test_se_o       = se_q;
   assign test_tm_o       = tm_q;
   assign scan_in_o       = scan_in_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed table, corner sequences and random ops against a pin-level model.
module tb_scan_sequencer;
   import part_tester_pkg::*;

   localparam int CLK_DIV    = 4;
   localparam int RST_CYCLES = 8;
   localparam int CNT_W      = 16;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cmd_valid_i = 1'b0;
   logic             cmd_ready_o;
   logic [2:0]       cmd_op_i = 3'd0;
   logic [CNT_W-1:0] cmd_count_i = '0;
   logic             pause_i = 1'b0;
   logic             bit_in_valid_i = 1'b0;
   logic             bit_in_i = 1'b0;
   logic             bit_in_ready_o;
   logic             bit_out_valid_o;
   logic             bit_out_o;
   logic             bit_out_ready_i = 1'b0;
   logic             done_o;
   logic [CNT_W-1:0] cycles_o;
   logic             part_clk_o, part_rstn_o, test_se_o, test_tm_o, scan_in_o;
   logic             scan_out_i;

   always #5 clk = ~clk;

   scan_sequencer #(.CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_count_i(cmd_count_i), .pause_i(pause_i),
      .bit_in_valid_i(bit_in_valid_i), .bit_in_i(bit_in_i), .bit_in_ready_o(bit_in_ready_o),
      .bit_out_valid_o(bit_out_valid_o), .bit_out_o(bit_out_o), .bit_out_ready_i(bit_out_ready_i),
      .done_o(done_o), .cycles_o(cycles_o), .part_clk_o(part_clk_o), .part_rstn_o(part_rstn_o),
      .test_se_o(test_se_o), .test_tm_o(test_tm_o), .scan_in_o(scan_in_o), .scan_out_i(scan_out_i)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- part model and pin monitor ----------------
   bit   chain_bits[64];
   int   chain_idx = 0;
   assign scan_out_i = chain_bits[chain_idx & 63];

   logic [2:0] cur_op = OP_RESET;
   int  edge_cnt = 0, high_run = 0, width_err = 0, pin_err = 0, order_err = 0, rstn_low_cnt = 0;
   bit  prev_clk = 1'b0, prev_hs_out = 1'b0, prev_valid_out = 1'b0, prev_bit_out = 1'b0;
   bit  si_q[$];
   bit  so_q[$];

   bit  in_bits[64];
   int  in_n = 0, in_ptr = 0, stall_idx = -1, stall_left = 0, stall_edges = -1, gap_pct = 0;
   bit  stall_clk = 1'b0;
   int  ready_hold = 0, ready_pct = 100;

   always @(negedge clk) begin
      if (part_clk_o && !prev_clk) begin
         edge_cnt++;
         chain_idx++;
         si_q.push_back(scan_in_o);
         if (test_se_o !== test_tm_o ||
             test_se_o !== ((cur_op == OP_SHIFT_IN) || (cur_op == OP_SHIFT_OUT)))
            pin_err++;
         if (cur_op == OP_SHIFT_OUT && !prev_hs_out) order_err++;
         if (cur_op == OP_SHIFT_IN && edge_cnt > in_ptr) order_err++;
      end
      if (part_clk_o) high_run++;
      else begin
         if (prev_clk && high_run != CLK_DIV) width_err++;
         high_run = 0;
      end
      if (!part_rstn_o) rstn_low_cnt++;
      if (bit_out_valid_o && prev_valid_out && !prev_hs_out && bit_out_o !== prev_bit_out) order_err++;
      if (bit_out_valid_o && bit_out_ready_i) so_q.push_back(bit_out_o);
      prev_hs_out    = bit_out_valid_o && bit_out_ready_i;
      prev_valid_out = bit_out_valid_o;
      prev_bit_out   = bit_out_o;
      prev_clk       = part_clk_o;
   end

   // Scan-bit producer: holds each bit until the valid/ready cycle, optional stall and gaps.
   initial begin
      bit hs;
      forever begin
         @(negedge clk);
         hs = bit_in_valid_i && bit_in_ready_o;
         @(posedge clk);
         #1;
         if (hs) begin
            in_ptr++;
            bit_in_valid_i = 1'b0;
         end
         if (!bit_in_valid_i && in_ptr < in_n) begin
            if (in_ptr == stall_idx && stall_left > 0) begin
               stall_left--;
               if (stall_left == 0) begin
                  stall_edges = edge_cnt;
                  stall_clk   = part_clk_o;
               end
            end else if ($urandom_range(99) >= gap_pct) begin
               bit_in_valid_i = 1'b1;
               bit_in_i       = in_bits[in_ptr];
            end
         end
      end
   end

   // Scan-bit consumer.
   initial begin
      forever begin
         step();
         if (ready_hold > 0) begin
            bit_out_ready_i = 1'b0;
            if (bit_out_valid_o) ready_hold--;
         end else begin
            bit_out_ready_i = ($urandom_range(99) < ready_pct);
         end
      end
   end

   task automatic clear_mon(input logic [2:0] op);
      cur_op = op;
      edge_cnt = 0; width_err = 0; pin_err = 0; order_err = 0; rstn_low_cnt = 0;
      chain_idx = 0; in_ptr = 0;
      si_q.delete();
      so_q.delete();
   endtask

   // Issue one op, wait for done and check it against the model's expectations.
   task automatic do_op(input logic [2:0] op, input int count, input int pause_after,
                        input int lo, input int hi);
      int guard, lat, bad, cyc;
      clear_mon(op);
      in_n = (op == OP_SHIFT_IN) ? count : 0;
      guard = 0;
      while (!cmd_ready_o && guard < 1000) begin step(); guard++; end
      check("cmd_ready_wait", 32'(guard < 1000), 1);
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_count_i = CNT_W'(count);
      pause_i     = (op == OP_FREE_RUN) ? (pause_after == 0) : 1'($urandom);
      step();
      cmd_valid_i = 1'b0;
      cmd_op_i    = 3'($urandom);
      cmd_count_i = CNT_W'($urandom);
      lat = 0;
      while (!done_o && lat < 20000) begin
         step();
         lat++;
         if (op == OP_FREE_RUN && pause_after > 0 && edge_cnt >= pause_after) pause_i = 1'b1;
      end
      check("done_seen", 32'(done_o), 1);
      cyc = int'(cycles_o);
      check_range("edges", edge_cnt, lo, hi);
      check("cycles_o", 32'(cyc), 32'(edge_cnt));
      check("clk_low_at_done", 32'(part_clk_o), 0);
      check("se_tm_at_done", {30'd0, test_se_o, test_tm_o}, 0);
      check("scan_in_at_done", 32'(scan_in_o), 0);
      check("high_width_err", 32'(width_err), 0);
      check("pin_err", 32'(pin_err), 0);
      check("handshake_order_err", 32'(order_err), 0);
      check("part_rstn_low", 32'(rstn_low_cnt), (op == OP_RESET) ? RST_CYCLES : 0);
      if (op == OP_EXECUTE)
         check_range("exec_latency", lat, 2 * CLK_DIV * count, 2 * CLK_DIV * count + 3);
      if (op == OP_SHIFT_IN) begin
         bad = 0;
         foreach (si_q[i]) if (i < 64 && si_q[i] != in_bits[i]) bad++;
         check("si_bit_count", 32'(si_q.size()), 32'(count));
         check("si_bits", 32'(bad), 0);
      end
      if (op == OP_SHIFT_OUT) begin
         bad = 0;
         foreach (so_q[i]) if (i < 64 && so_q[i] != chain_bits[i]) bad++;
         check("so_bit_count", 32'(so_q.size()), 32'(count));
         check("so_bits", 32'(bad), 0);
      end
      step();
      check("done_one_cycle", 32'(done_o), 0);
      check("ready_after_done", 32'(cmd_ready_o), 1);
      pause_i = 1'b0;
      $display("op=%0d count=%0d edges=%0d cycles_o=%0d latency=%0d", op, count, edge_cnt, cyc, lat);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) begin
         in_bits[i]    = 1'($urandom);
         chain_bits[i] = 1'($urandom);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      int         count;
      int         pause_after;
      int         exp_edges;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int e0, guard, op_sel, cnt, p, lo, hi;
      logic [2:0] rop;

      tbl[0]  = '{OP_RESET,     5, -1, 0};
      tbl[1]  = '{OP_EXECUTE,  10, -1, 10};
      tbl[2]  = '{OP_EXECUTE,   0, -1, 0};
      tbl[3]  = '{OP_EXECUTE,   1, -1, 1};
      tbl[4]  = '{OP_SHIFT_IN,  0, -1, 0};
      tbl[5]  = '{OP_SHIFT_OUT, 0, -1, 0};
      tbl[6]  = '{3'd5,         3, -1, 0};
      tbl[7]  = '{3'd6,         3, -1, 0};
      tbl[8]  = '{3'd7,         1, -1, 0};
      tbl[9]  = '{OP_FREE_RUN,  0,  0, 1};
      tbl[10] = '{OP_SHIFT_IN,  2, -1, 2};
      tbl[11] = '{OP_SHIFT_OUT, 3, -1, 3};

      // Reset values
      rstn = 1'b0;
      step();
      step();
      check("rst_part_clk", 32'(part_clk_o), 0);
      check("rst_part_rstn", 32'(part_rstn_o), 1);
      check("rst_se_tm_scan", {29'd0, test_se_o, test_tm_o, scan_in_o}, 0);
      check("rst_handshakes", {29'd0, bit_in_ready_o, bit_out_valid_o, bit_out_o}, 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_cycles", 32'(cycles_o), 0);
      rstn = 1'b1;
      step();
      check("rst_cmd_ready", 32'(cmd_ready_o), 1);

      // Directed table
      fill_random();
      for (int i = 0; i < 12; i++)
         do_op(tbl[i].op, tbl[i].count, tbl[i].pause_after, tbl[i].exp_edges, tbl[i].exp_edges);

      // Shift-in with a 20-cycle producer stall on bit 3
      in_bits[0] = 1; in_bits[1] = 0; in_bits[2] = 1; in_bits[3] = 0; in_bits[4] = 0; in_bits[5] = 1;
      stall_idx = 3; stall_left = 20; stall_edges = -1;
      do_op(OP_SHIFT_IN, 6, -1, 6, 6);
      check("stall_edges", 32'(stall_edges), 3);
      check("stall_clk_low", 32'(stall_clk), 0);
      stall_idx = -1;

      // Shift-out with consumer ready held low 15 cycles
      chain_bits[0] = 1; chain_bits[1] = 1; chain_bits[2] = 0; chain_bits[3] = 1;
      ready_hold = 15;
      do_op(OP_SHIFT_OUT, 4, -1, 4, 4);
      check("ready_hold_used", 32'(ready_hold), 0);

      // Free run with pause after 37 edges
      do_op(OP_FREE_RUN, 0, 37, 37, 38);

      // Reset in the middle of a shift-in
      fill_random();
      clear_mon(OP_SHIFT_IN);
      in_n = 6;
      cmd_valid_i = 1'b1; cmd_op_i = OP_SHIFT_IN; cmd_count_i = CNT_W'(6);
      step();
      cmd_valid_i = 1'b0;
      guard = 0;
      while (edge_cnt < 3 && guard < 2000) begin step(); guard++; end
      check("midop_reached", 32'(guard < 2000), 1);
      rstn = 1'b0;
      step();
      step();
      check("midop_rst_clk", 32'(part_clk_o), 0);
      check("midop_rst_se", 32'(test_se_o), 0);
      check("midop_rst_scan_in", 32'(scan_in_o), 0);
      check("midop_rst_cycles", 32'(cycles_o), 0);
      rstn = 1'b1;
      in_n = 0;
      bit_in_valid_i = 1'b0;
      e0 = edge_cnt;
      for (int i = 0; i < 30; i++) step();
      check("midop_no_edges", 32'(edge_cnt - e0), 0);
      check("midop_idle_ready", 32'(cmd_ready_o), 1);
      check("midop_no_done", 32'(done_o), 0);

      // Random ops against the model
      gap_pct = 30;
      ready_pct = 60;
      for (int n = 0; n < 30; n++) begin
         fill_random();
         op_sel = $urandom_range(7);
         cnt = $urandom_range(8);
         p = -1;
         case (op_sel)
            0: rop = OP_RESET;
            1, 2: rop = OP_SHIFT_IN;
            3: rop = OP_SHIFT_OUT;
            4: rop = OP_EXECUTE;
            5: rop = OP_FREE_RUN;
            default: rop = 3'($urandom_range(7, 5));
         endcase
         if (rop == OP_FREE_RUN) begin
            p = $urandom_range(6);
            lo = (p == 0) ? 1 : p;
            hi = (p == 0) ? 1 : p + 1;
         end else if (op_is_counted(rop)) begin
            lo = cnt;
            hi = cnt;
         end else begin
            lo = 0;
            hi = 0;
         end
         do_op(rop, cnt, p, lo, hi);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
